pulse_stretcher: RTL

Converts single-cycle enable pulses (as produced by the push-button one-pulser) back into human-visible level pulses of fixed length, separated by a guaranteed low gap. It sits downstream of the pulser, driving LEDs or a scope probe so that each accepted `clk_en` event becomes one observable high pulse. Pulses arriving while an output pulse is in progress are counted and replayed in order, up to a bounded backlog.

---
 rtl/pulse_stretcher.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_stretcher: stretches single-cycle clk_en events into fixed-length  |
// | high pulses with a guaranteed low gap, replaying a bounded backlog.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 5,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  output logic              pb_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] C_PEND_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [PEND_W-1:0]  pending_q,  pending_d;
  logic               overflow_q, overflow_d;
  logic               pb_out_q,   pb_out_d;
  logic               busy_q,     busy_d;

  logic cnt_zero;
  logic pend_zero;
  logic start;
  logic inc;
  logic dec;

  // The counter is loaded with length-1 so that "expired" means cnt==0 in the
  // last cycle of a phase; the transition then happens on that edge.
  always_comb begin
    cnt_zero  = (cnt_q == '0);
    pend_zero = (pending_q == '0);

    start = ((state_q == ST_IDLE) && clk_en) ||
            ((state_q == ST_GAP) && cnt_zero && (!pend_zero || clk_en));

    // Backlog is serviced before the live input.
    dec = start && !pend_zero;
    inc = clk_en && !(start && pend_zero);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HIGH;
          cnt_d   = C_HOLD_LOAD;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          state_d = ST_GAP;
          cnt_d   = C_GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (start) begin
          state_d = ST_HIGH;
          cnt_d   = C_HOLD_LOAD;
        end else if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    pb_out_d = (state_d == ST_HIGH);
    busy_d   = (state_d != ST_IDLE);
  end

  // A simultaneous inc and dec cancel, so a full backlog never overflows then.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;

    case ({inc, dec})
      2'b10: begin
        if (pending_q == C_PEND_MAX) begin
          overflow_d = 1'b1;
        end else begin
          pending_d = pending_q + 1'b1;
        end
      end
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      pb_out_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      pb_out_q   <= pb_out_d;
      busy_q     <= busy_d;
    end
  end

  assign pb_out   = pb_out_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire
